hash_host_ctrl: RTL and testbench
=================================

HASH_HOST_CTRL -- requirements
Module: hash_host_ctrl

Interface
REQ-001 SHALL have parameter MSG_BASE, default 16'h0000, meaning word address of message region.
REQ-002 SHALL have parameter OUT_BASE, default 16'h0100, meaning word address of digest region.
REQ-003 SHALL have parameter MAX_WORDS, default 256, meaning message capacity in 32-bit words (multiple of 16).
REQ-004 SHALL have ports: clk in 1 system clock; reset_en in 1 reset, asynchronous, active-low.
REQ-005 SHALL have host ports: cmd_go in 1 begin job; cmd_opcode in 2 hash select; in_valid in 1; in_ready out 1; in_data in 32 pre-padded message word; in_last in 1 final word; out_valid out 1; out_ready in 1; out_data out 32 digest word; out_last out 1; busy out 1; err out 1 sticky length error.
REQ-006 SHALL have core ports: start out 1; message_addr out 32; size out 32 (bytes); output_addr out 32; num_blocks out 16; opcode out 2; done in 1.
REQ-007 SHALL have memory ports: mem_addr out 16; mem_we out 1; mem_wdata out 32; mem_rdata in 32 (valid one cycle after address); core_mem_addr in 16; core_mem_we in 1; core_mem_wdata in 32.

Function
REQ-008 SHALL implement states IDLE, LOAD, START, RUN, RD_ISSUE, RD_WAIT, OUT_HOLD.
REQ-009 IDLE: in_ready=0, busy=0; cmd_go=1 latches cmd_opcode into opcode, clears word count and err, goes to LOAD.
REQ-010 LOAD: in_ready=1; each in_valid&in_ready cycle drives mem_we=1, mem_addr=MSG_BASE+count, mem_wdata=in_data, count+1 (16-bit).
REQ-011 LOAD: accepted word with in_last=1 goes to START if final count is nonzero and a multiple of 16, else sets err and returns to IDLE.
REQ-012 LOAD: an accepted word when count==MAX_WORDS SHALL not be written, SHALL set err, return to IDLE.
REQ-013 START: start=1 for exactly one cycle; message_addr={16'b0,MSG_BASE}; output_addr={16'b0,OUT_BASE}; size=count*4; num_blocks=count>>4; these hold stable until next IDLE->LOAD.
REQ-014 RUN: mem_addr/mem_we/mem_wdata SHALL equal core_mem_* combinationally; in all other states core_mem_* ignored and mem_we=0 except REQ-010.
REQ-015 RUN: done=1 goes to RD_ISSUE with digest index k=0; done in any other state ignored.
REQ-016 Digest length N: opcode 00->4, 01->5, 10->8, 11->8.
REQ-017 RD_ISSUE: mem_addr=OUT_BASE+k, go to RD_WAIT; RD_WAIT: register mem_rdata into out_data, out_valid=1, out_last=(k==N-1), go to OUT_HOLD.
REQ-018 OUT_HOLD: out_data/out_last stable while out_valid=1 and out_ready=0; on out_ready=1 clear out_valid, then k+1 to RD_ISSUE, or to IDLE if out_last.
REQ-019 Throughput: one digest word per at least 3 cycles; first out_valid exactly 2 cycles after done cycle.
REQ-020 busy=1 in every state except IDLE.
REQ-021 cmd_go outside IDLE SHALL be ignored; in_valid outside LOAD SHALL not be accepted.
REQ-022 err SHALL remain set until the next accepted cmd_go.

Reset
REQ-023 reset_en=0 SHALL asynchronously force state IDLE and all outputs to 0 (start, in_ready, out_valid, out_last, out_data, busy, err, mem_we, mem_addr, mem_wdata, message_addr, size, output_addr, num_blocks, opcode), count and k to 0.
REQ-024 Reset asserted mid-LOAD, RUN or readout SHALL abort the job; no write issued in the reset cycle; resumption only via new cmd_go.

Verification
REQ-025 cmd_go, opcode=00, 16 words 0..15 last on 16th -> writes addr 0..15, start one cycle, size=64, num_blocks=1; done -> 4 words from 0x100..0x103, out_last on 4th.
REQ-026 32 words, opcode=10, out_ready low 5 cycles per word -> num_blocks=2, size=128, 8 words held stable, each delivered once.
REQ-027 in_last on word 10 -> err=1, state IDLE, no start pulse; next cmd_go clears err.
REQ-028 257 words with MAX_WORDS=256 -> word 257 not written, err=1, IDLE.
REQ-029 In RUN, core_mem_we=1, addr 0x100, data 0xDEADBEEF -> mem port mirrors same cycle; in_valid ignored; cmd_go ignored.
REQ-030 reset_en low during readout of word 2 -> out_valid, busy, start 0 immediately; after release, IDLE, in_ready=0.

Source files
------------

// File: rtl/hash_host_ctrl.sv
// Host-side controller for a hash core: loads message words into memory,
// starts the core, then streams the digest back out through a handshake.
module hash_host_ctrl #(
  parameter logic [15:0] MSG_BASE  = 16'h0000,
  parameter logic [15:0] OUT_BASE  = 16'h0100,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_en,
  input  logic        cmd_go,
  input  logic [1:0]  cmd_opcode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err,
  output logic        start,
  output logic [31:0] message_addr,
  output logic [31:0] size,
  output logic [31:0] output_addr,
  output logic [15:0] num_blocks,
  output logic [1:0]  opcode,
  input  logic        done,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [15:0] core_mem_addr,
  input  logic        core_mem_we,
  input  logic [31:0] core_mem_wdata
);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, RUN, RD_ISSUE, RD_WAIT, OUT_HOLD
  } state_t;

  localparam logic [15:0] MAXW = 16'(MAX_WORDS);

  state_t      state;
  logic [15:0] count;
  logic [15:0] count_nx;
  logic [2:0]  k;
  logic [2:0]  last_k;
  logic        accept;
  logic        full;

  assign accept   = (state == LOAD) && in_valid;
  assign full     = (count == MAXW);
  assign count_nx = count + 16'd1;

  always_comb begin
    last_k = 3'd7;
    case (opcode)
      2'b00:   last_k = 3'd3;
      2'b01:   last_k = 3'd4;
      default: last_k = 3'd7;
    endcase
  end

  // Memory port is owned by the loader, the core (RUN) or the readout.
  always_comb begin
    mem_addr  = 16'd0;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    case (state)
      LOAD: begin
        mem_addr  = MSG_BASE + count;
        mem_wdata = in_data;
        mem_we    = in_valid && !full;
      end
      RUN: begin
        mem_addr  = core_mem_addr;
        mem_we    = core_mem_we;
        mem_wdata = core_mem_wdata;
      end
      RD_ISSUE: mem_addr = OUT_BASE + 16'(k);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      state        <= IDLE;
      count        <= '0;
      k            <= '0;
      in_ready     <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      busy         <= 1'b0;
      err          <= 1'b0;
      start        <= 1'b0;
      message_addr <= '0;
      size         <= '0;
      output_addr  <= '0;
      num_blocks   <= '0;
      opcode       <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_go) begin
          opcode   <= cmd_opcode;
          count    <= '0;
          err      <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          state    <= LOAD;
        end
        LOAD: if (accept) begin
          if (full) begin
            err      <= 1'b1;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (in_last) begin
            count    <= count_nx;
            in_ready <= 1'b0;
            if (count_nx[3:0] == 4'd0) begin
              start        <= 1'b1;
              message_addr <= {16'b0, MSG_BASE};
              output_addr  <= {16'b0, OUT_BASE};
              size         <= {14'b0, count_nx, 2'b00};
              num_blocks   <= {4'b0, count_nx[15:4]};
              state        <= START;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            count <= count_nx;
          end
        end
        START: begin
          start <= 1'b0;
          state <= RUN;
        end
        RUN: if (done) begin
          k     <= '0;
          state <= RD_ISSUE;
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
          out_data  <= mem_rdata;
          out_valid <= 1'b1;
          out_last  <= (k == last_k);
          state     <= OUT_HOLD;
        end
        OUT_HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          if (out_last) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            k     <= k + 3'd1;
            state <= RD_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_host_ctrl.sv
// Randomized bench for hash_host_ctrl: acts as host, hash core and memory,
// and checks load writes, start parameters and digest readout.
module tb_hash_host_ctrl;

  localparam logic [15:0] MB   = 16'h0000;
  localparam logic [15:0] OB   = 16'h0100;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        reset_en = 1'b0;
  logic        cmd_go = 1'b0;
  logic [1:0]  cmd_opcode = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        err;
  logic        start;
  logic [31:0] message_addr;
  logic [31:0] size;
  logic [31:0] output_addr;
  logic [15:0] num_blocks;
  logic [1:0]  opcode;
  logic        done = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [15:0] core_mem_addr = '0;
  logic        core_mem_we = 1'b0;
  logic [31:0] core_mem_wdata = '0;

  always #5 clk = ~clk;

  hash_host_ctrl #(
    .MSG_BASE (MB),
    .OUT_BASE (OB),
    .MAX_WORDS(MAXW)
  ) dut (
    .clk           (clk),
    .reset_en      (reset_en),
    .cmd_go        (cmd_go),
    .cmd_opcode    (cmd_opcode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .err           (err),
    .start         (start),
    .message_addr  (message_addr),
    .size          (size),
    .output_addr   (output_addr),
    .num_blocks    (num_blocks),
    .opcode        (opcode),
    .done          (done),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .core_mem_addr (core_mem_addr),
    .core_mem_we   (core_mem_we),
    .core_mem_wdata(core_mem_wdata)
  );

  logic [31:0] tmem [0:65535];

  always @(posedge clk) begin
    if (mem_we) tmem[mem_addr] <= mem_wdata;
    mem_rdata <= tmem[mem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;
  bit mirror_chk = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int n_dig(input logic [1:0] op);
    case (op)
      2'b00:   return 4;
      2'b01:   return 5;
      default: return 8;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle rule checks that hold regardless of the scenario
  logic        pv = 1'b0;
  logic        pl = 1'b0;
  logic        pready = 1'b0;
  logic        pstart = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    if (!reset_en) begin
      chk("rst_zero", 32'(|{start, in_ready, out_valid, out_last, out_data,
          busy, err, mem_we, mem_addr, mem_wdata, message_addr, size,
          output_addr, num_blocks, opcode}), 32'd0);
      pv = 1'b0;
      pstart = 1'b0;
    end else begin
      if (pv && !pready) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", out_data, pd);
        chk("hold_last", 32'(out_last), 32'(pl));
      end
      if (start) chk("start_single", 32'(pstart), 32'd0);
      if (in_ready) chk("ready_busy", 32'(busy), 32'd1);
      if (mirror_chk) begin
        chk("mirror_addr", 32'(mem_addr), 32'(core_mem_addr));
        chk("mirror_we", 32'(mem_we), 32'(core_mem_we));
        chk("mirror_wdata", mem_wdata, core_mem_wdata);
      end
      pv = out_valid;
      pd = out_data;
      pl = out_last;
      pready = out_ready;
      pstart = start;
    end
  end

  task automatic run_job(input int n, input logic [1:0] op, input int bp,
                         input bit seq, input int abort_at);
    int i;
    int nd;
    int c;
    int delivered;
    bit ok;
    logic [31:0] w;
    logic [31:0] dig [8];
    cmd_go = 1'b1;
    cmd_opcode = op;
    tick();
    cmd_go = 1'b0;
    @(negedge clk);
    chk("go_busy", 32'(busy), 32'd1);
    chk("go_ready", 32'(in_ready), 32'd1);
    chk("go_err", 32'(err), 32'd0);
    chk("go_opcode", 32'(opcode), 32'(op));
    tick();
    i = 0;
    while (i < n && i <= MAXW) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        chk("gap_we", 32'(mem_we), 32'd0);
        tick();
      end else begin
        w = seq ? 32'(i) : $urandom;
        in_valid = 1'b1;
        in_data = w;
        in_last = (i == n - 1);
        @(negedge clk);
        chk("load_ready", 32'(in_ready), 32'd1);
        chk("load_we", 32'(mem_we), 32'(i < MAXW));
        if (i < MAXW) begin
          chk("load_addr", 32'(mem_addr), 32'(MB + 16'(i)));
          chk("load_wdata", mem_wdata, w);
        end
        tick();
        i++;
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    ok = (n > 0) && (n <= MAXW) && (n % 16 == 0);
    @(negedge clk);
    if (!ok) begin
      chk("err_set", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_ready", 32'(in_ready), 32'd0);
      chk("err_start", 32'(start), 32'd0);
      tick();
      return;
    end
    chk("start_hi", 32'(start), 32'd1);
    chk("start_size", size, 32'(n * 4));
    chk("start_blocks", 32'(num_blocks), 32'(n / 16));
    chk("start_msg", message_addr, {16'b0, MB});
    chk("start_out", output_addr, {16'b0, OB});
    tick();
    @(negedge clk);
    chk("start_lo", 32'(start), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    tick();
    mirror_chk = 1'b1;
    core_mem_we = 1'b1;
    core_mem_addr = OB;
    core_mem_wdata = 32'hDEADBEEF;
    in_valid = 1'b1;
    cmd_go = 1'b1;
    cmd_opcode = ~op;
    @(negedge clk);
    chk("run_mem_addr", 32'(mem_addr), 32'h0000_0100);
    chk("run_mem_we", 32'(mem_we), 32'd1);
    chk("run_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("run_no_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    cmd_go = 1'b0;
    core_mem_we = 1'b0;
    @(negedge clk);
    chk("run_op_kept", 32'(opcode), 32'(op));
    chk("run_busy2", 32'(busy), 32'd1);
    tick();
    nd = n_dig(op);
    for (int j = 0; j < nd; j++) begin
      dig[j] = $urandom;
      core_mem_we = 1'b1;
      core_mem_addr = OB + 16'(j);
      core_mem_wdata = dig[j];
      @(negedge clk);
      tick();
    end
    core_mem_we = 1'b0;
    core_mem_addr = 16'($urandom);
    core_mem_wdata = $urandom;
    done = 1'b1;
    tick();
    done = 1'b0;
    mirror_chk = 1'b0;
    @(negedge clk);
    chk("lat_1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_2", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_first_valid", 32'(out_valid), 32'd1);
    delivered = 0;
    for (int kk = 0; kk < nd; kk++) begin
      c = 0;
      while (!out_valid && c < 8) begin
        tick();
        @(negedge clk);
        c++;
      end
      chk("out_wait", 32'(out_valid), 32'd1);
      if (kk == abort_at) begin
        #2 reset_en = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_start", 32'(start), 32'd0);
        chk("abort_data", out_data, 32'd0);
        tick();
        in_valid = 1'b1;
        in_data = $urandom;
        @(negedge clk);
        tick();
        reset_en = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_we", 32'(mem_we), 32'd0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        tick();
        return;
      end
      chk("out_data", out_data, dig[kk]);
      chk("out_last", 32'(out_last), 32'(kk == nd - 1));
      for (int h = 0; h < bp; h++) begin
        tick();
        @(negedge clk);
        chk("bp_data", out_data, dig[kk]);
      end
      tick();
      out_ready = 1'b1;
      @(negedge clk);
      tick();
      out_ready = 1'b0;
      @(negedge clk);
      chk("ack_drop", 32'(out_valid), 32'd0);
      delivered++;
    end
    chk("delivered", 32'(delivered), 32'(nd));
    chk("end_busy", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    reset_en = 1'b1;
    tick();
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    tick();

    run_job(16, 2'b00, 0, 1'b1, -1);
    chk("lit_size16", size, 32'd64);
    chk("lit_blocks16", 32'(num_blocks), 32'd1);
    chk("lit_outaddr", output_addr, 32'h0000_0100);

    run_job(32, 2'b10, 5, 1'b0, -1);
    chk("lit_size32", size, 32'd128);
    chk("lit_blocks32", 32'(num_blocks), 32'd2);

    run_job(10, 2'b01, 0, 1'b0, -1);
    repeat (3) begin
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      tick();
    end
    run_job(48, 2'b01, 1, 1'b0, -1);
    chk("err_cleared", 32'(err), 32'd0);

    run_job(257, 2'b11, 0, 1'b0, -1);
    @(negedge clk);
    chk("err_overflow", 32'(err), 32'd1);
    tick();

    repeat (4)
      run_job(16 * $urandom_range(1, 4), 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), 1'b0, -1);

    run_job(16, 2'b10, 2, 1'b0, 1);
    run_job(16, 2'b01, 0, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
